// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS constants: operand width, multiplier FSM states, function codes
package mips_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } mult_state_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;

    // Decode uses this to raise hi_lo_write_enable at the ID/EX boundary.
    function automatic logic is_mult_funct(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    endfunction

endpackage

// File: rtl/mult_hilo_unit_if.sv
// rtl/mult_hilo_unit_if.sv - execute-stage view of the HI/LO multiplier
interface mult_hilo_unit_if
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  start;
    logic                  flush;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  stall_req;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output start, flush, src_a, src_b,
        input  stall_req, busy, done, hi, lo
    );

    modport slave (
        input  start, flush, src_a, src_b,
        output stall_req, busy, done, hi, lo
    );
endinterface

// File: rtl/mult_shift_add_dp.sv
// rtl/mult_shift_add_dp.sv - radix-2 shift-add datapath; MULT_SIGNED_EN selects signed operands
module mult_shift_add_dp
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    load_i,
    input  logic                    step_i,
    input  logic [DATA_WIDTH-1:0]   src_a_i,
    input  logic [DATA_WIDTH-1:0]   src_b_i,
    output logic [2*DATA_WIDTH-1:0] product_o
);
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
    logic [DATA_WIDTH:0]     sum;
    logic [DATA_WIDTH-1:0]   mag_a, mag_b;

`ifdef MULT_SIGNED_EN
    logic neg_q, neg_d;

    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign mag_a     = src_a_i[DATA_WIDTH-1] ? -src_a_i : src_a_i;
    assign mag_b     = src_b_i[DATA_WIDTH-1] ? -src_b_i : src_b_i;
    assign product_o = neg_q ? -acc_q : acc_q;
`else
    assign mag_a     = src_a_i;
    assign mag_b     = src_b_i;
    assign product_o = acc_q;
`endif

    always_comb begin
        sum      = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                 + {1'b0, (mplier_q[0] ? mcand_q : {DATA_WIDTH{1'b0}})};
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`ifdef MULT_SIGNED_EN
        neg_d    = neg_q;
`endif
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = mag_a;
            mplier_d = mag_b;
`ifdef MULT_SIGNED_EN
            neg_d    = src_a_i[DATA_WIDTH-1] ^ src_b_i[DATA_WIDTH-1];
`endif
        end else if (step_i) begin
            acc_d    = {sum, acc_q[DATA_WIDTH-1:1]};
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`ifdef MULT_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`ifdef MULT_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end
endmodule

// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - iterative multiplier FSM, pipeline stall and HI/LO registers (MULT_SIGNED_EN for mult)
module mult_hilo_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    mult_hilo_unit_if.slave  bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    mult_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;
    logic                    done_q, done_d;
    logic                    load, step, accept;
    logic [2*DATA_WIDTH-1:0] product;

    assign accept = bus.start & ~bus.flush;

    mult_shift_add_dp #(.DATA_WIDTH(DATA_WIDTH)) u_dp (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_i    (load),
        .step_i    (step),
        .src_a_i   (bus.src_a),
        .src_b_i   (bus.src_b),
        .product_o (product)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                // A flushed product never reaches HI/LO, so mfhi/mflo see only whole results.
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    hi_d   = product[2*DATA_WIDTH-1:DATA_WIDTH];
                    lo_d   = product[DATA_WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.stall_req = (state_q == ST_IDLE) ? accept : 1'b1;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - directed bench for mult_hilo_unit (MULT_SIGNED_EN picks expected values)
module tb_mult_hilo_unit;
    logic clock;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    mult_hilo_unit_if bus ();

    mult_hilo_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.src_a = a;
        bus.src_b = b;
    endtask

    // Cycle 1 is the start cycle; returns with the bench sitting in the done cycle.
    task automatic wait_done(output int stalls, output int done_cyc, output bit ok);
        int cyc;
        stalls   = 0;
        done_cyc = 0;
        ok       = 1'b0;
        cyc      = 1;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (bus.stall_req === 1'b1) stalls++;
            if (cyc > 1 && bus.done === 1'b1) begin
                done_cyc = cyc;
                ok       = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
            bus.start = 1'b0;
            @(negedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic mult_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int st, dc;
        bit ok;
        issue(a, b);
        wait_done(st, dc, ok);
        chk({tag, "_completes"}, ok, 1);
        chk({tag, "_latency"}, dc, 35);
        chk({tag, "_hi"}, bus.hi, exp_hi);
        chk({tag, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        int st, dc, seen;
        bit ok;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (2) @(negedge clock);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_hi", bus.hi, 0);
        chk("reset_lo", bus.lo, 0);
        chk("reset_stall", bus.stall_req, 0);
        @(negedge clock);
        reset_n = 1'b1;

        issue(32'd3, 32'd5);
        wait_done(st, dc, ok);
        chk("3x5_completes", ok, 1);
        chk("3x5_stall_cycles", st, 34);
        chk("3x5_done_cycle", dc, 35);
        chk("3x5_busy_at_done", bus.busy, 0);
        chk("3x5_hi", bus.hi, 32'h0);
        chk("3x5_lo", bus.lo, 32'hF);
        @(negedge clock);
        #1;
        chk("done_one_cycle", bus.done, 0);

`ifdef MULT_SIGNED_EN
        mult_check("neg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        mult_check("min_x1", 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000);
        mult_check("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
`else
        mult_check("neg3x5", 32'hFFFF_FFFD, 32'd5, 32'h4, 32'hFFFF_FFF1);
        mult_check("min_x1", 32'h8000_0000, 32'd1, 32'h0, 32'h8000_0000);
        mult_check("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
`endif
        mult_check("zero_op", 32'h0, 32'h0001_2345, 32'h0, 32'h0);

        // Flush mid-CALC must leave the previous 42 in HI/LO.
        mult_check("7x6", 32'd7, 32'd6, 32'h0, 32'd42);
        issue(32'd2, 32'd2);
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        chk("flush_idle", bus.busy, 0);
        chk("flush_no_done", bus.done, 0);
        chk("flush_hi", bus.hi, 32'h0);
        chk("flush_lo", bus.lo, 32'd42);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            #1;
            if (bus.done === 1'b1) seen++;
        end
        chk("flush_no_late_done", seen, 0);
        chk("flush_lo_held", bus.lo, 32'd42);

        issue(32'd4, 32'd4);
        wait_done(st, dc, ok);
        chk("b2b_first_completes", ok, 1);
        chk("b2b_first_lo", bus.lo, 32'd16);
        bus.start = 1'b1;
        bus.src_a = 32'h0001_0000;
        bus.src_b = 32'h0001_0000;
        #1;
        chk("b2b_stall_in_done_cycle", bus.stall_req, 1);
        wait_done(st, dc, ok);
        chk("b2b_second_completes", ok, 1);
        chk("b2b_second_latency", dc, 35);
        chk("b2b_hi", bus.hi, 32'h1);
        chk("b2b_lo", bus.lo, 32'h0);

        // Asynchronous reset after step 16 discards the partial product.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 0; k < 17; k++) begin
            @(posedge clock);
            #1;
            bus.start = 1'b0;
        end
        chk("pre_reset_busy", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        chk("areset_busy", bus.busy, 0);
        chk("areset_done", bus.done, 0);
        chk("areset_hi", bus.hi, 0);
        chk("areset_lo", bus.lo, 0);
        chk("areset_stall", bus.stall_req, 0);
        @(negedge clock);
        reset_n = 1'b1;
        mult_check("after_reset_1x1", 32'd1, 32'd1, 32'h0, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
